// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the sync-pattern frame transmitter and its matching detectors.
// Holds the FSM state type, the default sync pattern and a small width helper.
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_e;

    localparam int SYNC_LEN = 5;
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 5'b00110;

    // Largest of three sizes; used to size the shared bit index counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pattern_bit_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 while enabled, and marks the
// first and last clk cycle of every serial bit. It is held at zero when disabled.
module pattern_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_start,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Period counter, wrapping at the last count of each bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (!enable) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign bit_start = enable && (cnt_r == CNT_ZERO);
    assign bit_end   = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/pattern_frame_tx.sv
// Serial frame transmitter: takes one payload word over valid/ready, then sends
// the sync pattern followed by the payload MSB first, with an optional idle gap.
module pattern_frame_tx
    import pattern_tx_pkg::*;
#(
    parameter int                 DATA_W       = 8,
    parameter int                 PAT_LEN      = SYNC_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN      = SYNC_PATTERN,
    parameter int                 CLKS_PER_BIT = 1,
    parameter int                 GAP_BITS     = 0,
    parameter logic               IDLE_LEVEL   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              serial_out,
    output logic              bit_strobe,
    output logic              busy,
    output logic              frame_done
);

    localparam int FRAME_W = PAT_LEN + DATA_W;
    localparam int IDX_MAX = max3(PAT_LEN, DATA_W, GAP_BITS) - 1;
    localparam int IDX_W   = (IDX_MAX > 0) ? $clog2(IDX_MAX + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_e          state_r, state_nx_s;
    logic [IDX_W-1:0]   idx_r, idx_nx_s;
    logic [FRAME_W-1:0] shift_r, shift_nx_s, load_s;
    logic               serial_out_r, serial_nx_s;
    logic               busy_r;
    logic               in_ready_s, take_s;
    logic               timer_en_s, bit_start_s, bit_end_s;

    assign in_ready_s = (state_r == IDLE) && !rst;
    assign take_s     = in_valid && in_ready_s;
    assign timer_en_s = (state_r != IDLE);
    // Pattern and payload share one shift register so the line is always its MSB.
    assign load_s     = {PATTERN, in_data};

    pattern_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .enable    (timer_en_s),
        .bit_start (bit_start_s),
        .bit_end   (bit_end_s)
    );

    // Next-state, bit index, shift register and next serial level
    always_comb begin
        state_nx_s  = state_r;
        idx_nx_s    = idx_r;
        shift_nx_s  = shift_r;
        serial_nx_s = serial_out_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_nx_s  = SYNC;
                    idx_nx_s    = SYNC_LAST;
                    shift_nx_s  = load_s;
                    serial_nx_s = load_s[FRAME_W-1];
                end else begin
                    serial_nx_s = IDLE_LEVEL;
                end
            end
            SYNC: begin
                if (bit_end_s) begin
                    shift_nx_s  = {shift_r[FRAME_W-2:0], 1'b0};
                    serial_nx_s = shift_r[FRAME_W-2];
                    if (idx_r == IDX_ZERO) begin
                        state_nx_s = DATA;
                        idx_nx_s   = DATA_LAST;
                    end else begin
                        idx_nx_s   = idx_r - IDX_ONE;
                    end
                end else begin
                    serial_nx_s = serial_out_r;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_nx_s = {shift_r[FRAME_W-2:0], 1'b0};
                    if (idx_r == IDX_ZERO) begin
                        serial_nx_s = IDLE_LEVEL;
                        if (GAP_BITS > 0) begin
                            state_nx_s = GAP;
                            idx_nx_s   = GAP_LAST;
                        end else begin
                            state_nx_s = IDLE;
                            idx_nx_s   = IDX_ZERO;
                        end
                    end else begin
                        serial_nx_s = shift_r[FRAME_W-2];
                        idx_nx_s    = idx_r - IDX_ONE;
                    end
                end else begin
                    serial_nx_s = serial_out_r;
                end
            end
            GAP: begin
                serial_nx_s = IDLE_LEVEL;
                if (bit_end_s && (idx_r == IDX_ZERO)) begin
                    state_nx_s = IDLE;
                end else if (bit_end_s) begin
                    idx_nx_s = idx_r - IDX_ONE;
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            default: begin
                state_nx_s  = IDLE;
                idx_nx_s    = IDX_ZERO;
                serial_nx_s = IDLE_LEVEL;
            end
        endcase
    end

    // State and registered line outputs; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= IDX_ZERO;
            shift_r      <= {FRAME_W{1'b0}};
            serial_out_r <= IDLE_LEVEL;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            idx_r        <= idx_nx_s;
            shift_r      <= shift_nx_s;
            serial_out_r <= serial_nx_s;
            busy_r       <= (state_nx_s != IDLE);
        end
    end

    assign in_ready   = in_ready_s;
    assign serial_out = serial_out_r;
    assign busy       = busy_r;
    assign bit_strobe = bit_start_s && ((state_r == SYNC) || (state_r == DATA));
    assign frame_done = (state_r == DATA) && (idx_r == IDX_ZERO) && bit_end_s;

endmodule

// File: tb/tb_pattern_frame_tx.sv
// Scoreboard bench for pattern_frame_tx: three instances (default timing, slow bits,
// slow bits with gap); expected frames are queued at send time and checked by a monitor.
module tb_pattern_frame_tx;

    localparam logic [4:0] PAT = 5'b00110;

    logic       clk;
    logic       rst;
    logic       iv[3];
    logic [7:0] idata[3];
    logic       rdy[3], ser[3], stb[3], bsy[3], dn[3];

    logic [12:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    pattern_frame_tx u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idata[0]), .in_ready(rdy[0]),
        .serial_out(ser[0]), .bit_strobe(stb[0]), .busy(bsy[0]), .frame_done(dn[0])
    );

    pattern_frame_tx #(.CLKS_PER_BIT(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idata[1]), .in_ready(rdy[1]),
        .serial_out(ser[1]), .bit_strobe(stb[1]), .busy(bsy[1]), .frame_done(dn[1])
    );

    pattern_frame_tx #(.CLKS_PER_BIT(2), .GAP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(idata[2]), .in_ready(rdy[2]),
        .serial_out(ser[2]), .bit_strobe(stb[2]), .busy(bsy[2]), .frame_done(dn[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offer a word at the current negedge; returns at the negedge after the handshake.
    task automatic send(input int d, input logic [7:0] data);
        int n;
        n = 0;
        iv[d] = 1'b1;
        idata[d] = data;
        while (!rdy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            chk("ready_timeout", 32'd0, 32'd1);
            iv[d] = 1'b0;
        end else begin
            exp_q.push_back({PAT, data});
            @(negedge clk);
            iv[d] = 1'b0;
        end
    endtask

    // Send one word and check every output cycle by cycle until in_ready returns.
    task automatic check_frame(input int d, input logic [7:0] data, input int cpb, input int gapc);
        logic [12:0] fr;
        int tot, last, b;
        fr   = {PAT, data};
        tot  = 13 * cpb;
        last = tot + gapc * cpb + 1;
        send(d, data);
        for (int c = 1; c <= last; c++) begin
            b = (c <= tot) ? 12 - (c - 1) / cpb : 0;
            chk($sformatf("d%0d_serial_c%0d", d, c), ser[d], (c <= tot) ? fr[b] : 1'b1);
            chk($sformatf("d%0d_strobe_c%0d", d, c), stb[d], (c <= tot) && ((c - 1) % cpb == 0));
            chk($sformatf("d%0d_busy_c%0d", d, c), bsy[d], c < last);
            chk($sformatf("d%0d_ready_c%0d", d, c), rdy[d], c == last);
            chk($sformatf("d%0d_done_c%0d", d, c), dn[d], c == tot);
            if (c < last) @(negedge clk);
        end
    endtask

    // Monitor: assemble strobed bits and compare against the queue on frame_done
    initial begin
        logic [12:0] col[3];
        int ncol[3];
        logic [12:0] e;
        for (int i = 0; i < 3; i++) begin
            col[i] = 13'd0;
            ncol[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst || !bsy[i]) begin
                    col[i] = 13'd0;
                    ncol[i] = 0;
                end else begin
                    if (stb[i]) begin
                        col[i] = {col[i][11:0], ser[i]};
                        ncol[i]++;
                    end
                    if (dn[i]) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("d%0d_unexpected_done", i), 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("d%0d_frame", i), col[i], e);
                            chk($sformatf("d%0d_frame_bits", i), ncol[i], 32'd13);
                        end
                        col[i] = 13'd0;
                        ncol[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            idata[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), rdy[i], 32'd0);
            chk($sformatf("rst_serial%0d", i), ser[i], 32'd1);
            chk($sformatf("rst_busy%0d", i), bsy[i], 32'd0);
            chk($sformatf("rst_strobe%0d", i), stb[i], 32'd0);
            chk($sformatf("rst_done%0d", i), dn[i], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("idle_ready%0d", i), rdy[i], 32'd1);

        // Default timing, A5: 0011010100101
        check_frame(0, 8'hA5, 1, 0);
        // Three clocks per bit, zero payload
        check_frame(1, 8'h00, 3, 0);
        // Two clocks per bit with a two-bit idle gap
        check_frame(2, 8'h5A, 2, 2);

        // Back-to-back: valid held high across both words
        @(negedge clk);
        chk("b2b_ready0", rdy[0], 32'd1);
        iv[0] = 1'b1;
        idata[0] = 8'hFF;
        exp_q.push_back({PAT, 8'hFF});
        @(negedge clk);
        idata[0] = 8'h0F;
        exp_q.push_back({PAT, 8'h0F});
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("b2b_done_c%0d", c), dn[0], c == 13);
            if (c == 14) begin
                chk("b2b_gap_ready", rdy[0], 32'd1);
                chk("b2b_gap_serial", ser[0], 32'd1);
                chk("b2b_gap_busy", bsy[0], 32'd0);
            end else if (c == 15) begin
                chk("b2b_second_busy", bsy[0], 32'd1);
                chk("b2b_second_ready", rdy[0], 32'd0);
                chk("b2b_second_serial", ser[0], 32'd0);
                chk("b2b_second_strobe", stb[0], 32'd1);
                iv[0] = 1'b0;
            end
            if (c < 15) @(negedge clk);
        end
        repeat (14) @(negedge clk);
        chk("b2b_idle_after", bsy[0], 32'd0);

        // Reset during data bit 3 aborts the frame
        send(0, 8'hC3);
        repeat (9) @(negedge clk);
        chk("abort_busy_before", bsy[0], 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_serial", ser[0], 32'd1);
        chk("abort_busy", bsy[0], 32'd0);
        chk("abort_ready_in_rst", rdy[0], 32'd0);
        chk("abort_done", dn[0], 32'd0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", rdy[0], 32'd1);
        repeat (3) @(negedge clk);
        check_frame(0, 8'h3C, 1, 0);

        // Input activity while busy must not disturb the held word
        @(negedge clk);
        send(0, 8'h96);
        for (int c = 1; c <= 15; c++) begin
            logic [12:0] fr;
            fr = {PAT, 8'h96};
            chk($sformatf("hold_serial_c%0d", c), ser[0], (c <= 13) ? fr[13 - c] : 1'b1);
            chk($sformatf("hold_ready_c%0d", c), rdy[0], c >= 14);
            chk($sformatf("hold_busy_c%0d", c), bsy[0], c <= 13);
            iv[0] = (c < 12) ? c[0] : 1'b0;
            idata[0] = 8'(c * 37);
            if (c < 15) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("hold_no_extra_frame", bsy[0], 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
